polyveck_make_hint_stream: RTL and testbench

Sequential, parametrised generation of the polynomial-vector hint computation for signing. Consumes the K×N coefficient pairs (a0, a1) as a valid/ready stream, one pair per cycle, and computes the hint bit per coefficient. Emits a registered hint stream carrying coefficient index, polynomial number and running count, ready for signature hint packing. Reports the total hint count and an OMEGA-overflow flag so the signer can reject and restart.

---
 rtl/dilithium_pkg.sv | 25 ++
 rtl/make_hint_coef.sv | 22 ++
 rtl/polyveck_make_hint_stream.sv | 144 ++++++++++++++
 tb/tb_polyveck_make_hint_stream.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dilithium_pkg.sv
// Shared Dilithium constants and the hint-stream FSM state type.
package dilithium_pkg;

    localparam int Q         = 8380417;
    localparam int DIL_N     = 256;

    // Low-order rounding ranges for the three security levels.
    localparam int GAMMA2_88 = (Q - 1) / 88;
    localparam int GAMMA2_32 = (Q - 1) / 32;

    // Maximum legal hint count per security level.
    localparam int OMEGA_L2  = 80;
    localparam int OMEGA_L3  = 55;
    localparam int OMEGA_L5  = 75;

    localparam int K_L3      = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } hint_state_t;

endpackage

// File: rtl/make_hint_coef.sv
// Combinational single-coefficient hint: h = 1 when a0 leaves the
// [-GAMMA2, GAMMA2] window, or sits exactly on -GAMMA2 with a nonzero a1.
module make_hint_coef #(
    parameter int COEF_W = 32,
    parameter int GAMMA2 = 261888
) (
    input  logic signed [COEF_W-1:0] a0,
    input  logic signed [COEF_W-1:0] a1,
    output logic                     h
);

    localparam logic signed [COEF_W-1:0] G_POS = COEF_W'(GAMMA2);
    localparam logic signed [COEF_W-1:0] G_NEG = -G_POS;

    function automatic logic hint_rule(input logic signed [COEF_W-1:0] lo,
                                       input logic signed [COEF_W-1:0] hi);
        return (lo > G_POS) || (lo < G_NEG) || ((lo == G_NEG) && (hi != '0));
    endfunction

    assign h = hint_rule(a0, a1);

endmodule

// File: rtl/polyveck_make_hint_stream.sv
// Streams K*N coefficient pairs through the hint rule and emits a registered
// hint beat per pair, tagged with index, polynomial and running hint count.
// Reports the pass total and an OMEGA-overflow flag at the end of each pass.
module polyveck_make_hint_stream
    import dilithium_pkg::*;
#(
    parameter int K      = K_L3,
    parameter int N      = DIL_N,
    parameter int COEF_W = 32,
    parameter int GAMMA2 = GAMMA2_32,
    parameter int OMEGA  = OMEGA_L3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [COEF_W-1:0] in_a0,
    input  logic signed [COEF_W-1:0] in_a1,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_hint,
    output logic [$clog2(N)-1:0]     out_idx,
    output logic [$clog2(K)-1:0]     out_poly,
    output logic                     out_poly_last,
    output logic [31:0]              out_cum_count,
    output logic                     busy,
    output logic                     done,
    output logic [31:0]              count,
    output logic                     overflow
);

    localparam int IDX_W  = $clog2(N);
    localparam int POLY_W = $clog2(K);

    hint_state_t        state;
    logic [IDX_W-1:0]   coef_cnt;
    logic [POLY_W-1:0]  poly_cnt;
    logic [31:0]        run_count;
    logic               h;
    logic               accept;
    logic               out_fire;
    logic               coef_last;
    logic               vec_last;
    logic [31:0]        h_ext;

    make_hint_coef #(
        .COEF_W (COEF_W),
        .GAMMA2 (GAMMA2)
    ) u_coef (
        .a0 (in_a0),
        .a1 (in_a1),
        .h  (h)
    );

    // No skid buffer: a new pair is taken only if the output slot frees this cycle.
    assign in_ready  = (state == ST_RUN) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign coef_last = (coef_cnt == IDX_W'(N - 1));
    assign vec_last  = coef_last && (poly_cnt == POLY_W'(K - 1));
    assign h_ext     = {31'd0, h};

    // Pass control: counters, running hint total and end-of-pass reporting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            coef_cnt  <= '0;
            poly_cnt  <= '0;
            run_count <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        coef_cnt  <= '0;
                        poly_cnt  <= '0;
                        run_count <= '0;
                        count     <= '0;
                        overflow  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        run_count <= run_count + h_ext;
                        if (coef_last) begin
                            coef_cnt <= '0;
                            poly_cnt <= poly_cnt + POLY_W'(1);
                        end else begin
                            coef_cnt <= coef_cnt + IDX_W'(1);
                        end
                        if (vec_last) begin
                            busy  <= 1'b0;
                            state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    // The final beat is still in the output register; wait for it to leave.
                    if (out_fire) begin
                        count    <= run_count;
                        overflow <= (run_count > 32'(OMEGA));
                        done     <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output beat register: reload on accept, drain on handshake, hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_hint      <= 1'b0;
            out_idx       <= '0;
            out_poly      <= '0;
            out_poly_last <= 1'b0;
            out_cum_count <= '0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_hint      <= h;
            out_idx       <= coef_cnt;
            out_poly      <= poly_cnt;
            out_poly_last <= coef_last;
            out_cum_count <= run_count + h_ext;
        end else if (out_fire) begin
            out_valid     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_polyveck_make_hint_stream.sv
// Bench for polyveck_make_hint_stream: three parameterisations share one
// stimulus bus; a per-beat software model of the hint rule checks every beat.
module tb_polyveck_make_hint_stream;

    localparam int NN = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic [2:0]         start_vec;
    logic               in_valid;
    logic signed [31:0] in_a0;
    logic signed [31:0] in_a1;
    logic               out_ready;

    logic ir6, ov6, oh6, pl6, bz6, dn6, of6;
    logic [7:0] ix6; logic [2:0] pp6; logic [31:0] cc6, ct6;
    logic ir4, ov4, oh4, pl4, bz4, dn4, of4;
    logic [7:0] ix4; logic [1:0] pp4; logic [31:0] cc4, ct4;
    logic ir8, ov8, oh8, pl8, bz8, dn8, of8;
    logic [7:0] ix8; logic [2:0] pp8; logic [31:0] cc8, ct8;

    polyveck_make_hint_stream #(.K(6), .N(256), .COEF_W(32), .GAMMA2(261888), .OMEGA(55)) dut6 (
        .clk(clk), .rst_n(rst_n), .start(start_vec[0]), .in_valid(in_valid), .in_ready(ir6),
        .in_a0(in_a0), .in_a1(in_a1), .out_valid(ov6), .out_ready(out_ready), .out_hint(oh6),
        .out_idx(ix6), .out_poly(pp6), .out_poly_last(pl6), .out_cum_count(cc6),
        .busy(bz6), .done(dn6), .count(ct6), .overflow(of6));

    polyveck_make_hint_stream #(.K(4), .N(256), .COEF_W(32), .GAMMA2(95232), .OMEGA(80)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start_vec[1]), .in_valid(in_valid), .in_ready(ir4),
        .in_a0(in_a0), .in_a1(in_a1), .out_valid(ov4), .out_ready(out_ready), .out_hint(oh4),
        .out_idx(ix4), .out_poly(pp4), .out_poly_last(pl4), .out_cum_count(cc4),
        .busy(bz4), .done(dn4), .count(ct4), .overflow(of4));

    polyveck_make_hint_stream #(.K(8), .N(256), .COEF_W(32), .GAMMA2(261888), .OMEGA(75)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start_vec[2]), .in_valid(in_valid), .in_ready(ir8),
        .in_a0(in_a0), .in_a1(in_a1), .out_valid(ov8), .out_ready(out_ready), .out_hint(oh8),
        .out_idx(ix8), .out_poly(pp8), .out_poly_last(pl8), .out_cum_count(cc8),
        .busy(bz8), .done(dn8), .count(ct8), .overflow(of8));

    int sel;
    logic m_ir, m_ov, m_oh, m_pl, m_bz, m_dn, m_of;
    logic [7:0] m_ix; logic [2:0] m_pp; logic [31:0] m_cc, m_ct;

    // Route the selected instance onto one set of observation signals.
    always_comb begin
        m_ir = ir6; m_ov = ov6; m_oh = oh6; m_pl = pl6; m_bz = bz6; m_dn = dn6; m_of = of6;
        m_ix = ix6; m_pp = pp6; m_cc = cc6; m_ct = ct6;
        case (sel)
            1: begin
                m_ir = ir4; m_ov = ov4; m_oh = oh4; m_pl = pl4; m_bz = bz4; m_dn = dn4; m_of = of4;
                m_ix = ix4; m_pp = {1'b0, pp4}; m_cc = cc4; m_ct = ct4;
            end
            2: begin
                m_ir = ir8; m_ov = ov8; m_oh = oh8; m_pl = pl8; m_bz = bz8; m_dn = dn8; m_of = of8;
                m_ix = ix8; m_pp = pp8; m_cc = cc8; m_ct = ct8;
            end
            default: ;
        endcase
    end

    int total = 0;
    int bad   = 0;

    int a0_mem [2048];
    int a1_mem [2048];
    int exp_hint [2048];
    int exp_cum [2048];
    int obs_hint [2048];
    int obs_cum [2048];
    logic obs_last [2048];
    int model_total;
    int n_out;
    int done_seen;
    int done_cyc;

    function automatic int ref_hint(int a0, int a1, int g);
        if (a0 > g) return 1;
        if (a0 < -g) return 1;
        if ((a0 == -g) && (a1 != 0)) return 1;
        return 0;
    endfunction

    task automatic fill_zero();
        for (int i = 0; i < 2048; i++) begin
            a0_mem[i] = 0;
            a1_mem[i] = 0;
        end
    endtask

    task automatic fill_random(int g, int pct);
        for (int i = 0; i < 2048; i++) begin
            a1_mem[i] = int'($urandom_range(0, 3)) - 1;
            if (int'($urandom_range(0, 99)) < pct) begin
                case ($urandom_range(0, 4))
                    0: a0_mem[i] = g;
                    1: a0_mem[i] = g + 1;
                    2: a0_mem[i] = -g;
                    3: a0_mem[i] = -g - 1;
                    default: a0_mem[i] = int'($urandom());
                endcase
            end else begin
                a0_mem[i] = int'($urandom_range(0, 2 * g - 2)) - (g - 1);
            end
        end
    endtask

    // Drive one vector pass on instance 'sel' and check every beat against the model.
    task automatic run_pass(int k, int g, int omega, bit bp, int abort_at);
        int beats, in_ptr, cum;
        bit stalled, finished;
        logic s_h, s_pl; logic [7:0] s_ix; logic [2:0] s_pp; logic [31:0] s_cc;
        beats = k * NN;
        cum = 0;
        for (int i = 0; i < beats; i++) begin
            exp_hint[i] = ref_hint(a0_mem[i], a1_mem[i], g);
            cum += exp_hint[i];
            exp_cum[i] = cum;
        end
        model_total = cum;
        in_ptr = 0; n_out = 0; done_seen = 0; done_cyc = 0;
        stalled = 0; finished = 0;
        s_h = 0; s_pl = 0; s_ix = 0; s_pp = 0; s_cc = 0;
        @(negedge clk);
        start_vec = 3'(1 << sel);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 1; cyc <= beats * 6 + 50 && !finished; cyc++) begin
            @(negedge clk);
            start_vec = 3'b000;
            if (stalled) begin
                total++;
                if (m_ov !== 1'b1 || m_oh !== s_h || m_ix !== s_ix || m_pp !== s_pp ||
                    m_cc !== s_cc || m_pl !== s_pl) begin
                    bad++;
                    $display("FAIL stall_hold cyc=%0d got v=%b h=%b idx=%0d poly=%0d cum=%0d want h=%b idx=%0d poly=%0d cum=%0d",
                             cyc, m_ov, m_oh, m_ix, m_pp, m_cc, s_h, s_ix, s_pp, s_cc);
                end
            end
            if (cyc == 1) begin
                total++;
                if (m_bz !== 1'b1) begin
                    bad++;
                    $display("FAIL busy_after_start got=%b want=1", m_bz);
                end
            end
            if (m_dn === 1'b1) begin
                done_seen++;
                if (done_seen == 1) begin
                    done_cyc = cyc;
                    total++;
                    if (m_ct !== 32'(model_total) || m_of !== (model_total > omega) || n_out != beats) begin
                        bad++;
                        $display("FAIL pass_result got count=%0d ovf=%b beats=%0d want count=%0d ovf=%b beats=%0d",
                                 m_ct, m_of, n_out, model_total, (model_total > omega), beats);
                    end
                end
            end
            if (done_seen > 0 && cyc == done_cyc + 1) begin
                total++;
                if (m_bz !== 1'b0 || m_ir !== 1'b0) begin
                    bad++;
                    $display("FAIL idle_after_done got busy=%b in_ready=%b want 0 0", m_bz, m_ir);
                end
            end
            if (done_seen > 0 && cyc >= done_cyc + 3) finished = 1;
            if (abort_at >= 0 && n_out >= abort_at) break;
            in_valid  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            in_a0 = (in_ptr < beats) ? a0_mem[in_ptr] : int'($urandom());
            in_a1 = (in_ptr < beats) ? a1_mem[in_ptr] : int'($urandom());
            if (bp && cyc == 40) start_vec = 3'(1 << sel);
            #1;
            if (in_valid && m_ir) begin
                if (in_ptr < beats) in_ptr++;
                else begin
                    total++; bad++;
                    $display("FAIL extra_accept got=%0d want=%0d", in_ptr + 1, beats);
                end
            end
            if (m_ov && out_ready) begin
                total++;
                if (n_out >= beats) begin
                    bad++;
                    $display("FAIL extra_beat got=%0d want=%0d", n_out + 1, beats);
                end else begin
                    obs_hint[n_out] = int'(m_oh);
                    obs_cum[n_out]  = int'(m_cc);
                    obs_last[n_out] = m_pl;
                    if (m_oh !== (exp_hint[n_out] != 0) || m_ix !== 8'(n_out % NN) ||
                        m_pp !== 3'(n_out / NN) || m_pl !== ((n_out % NN) == NN - 1) ||
                        m_cc !== 32'(exp_cum[n_out])) begin
                        bad++;
                        $display("FAIL beat n=%0d got h=%b idx=%0d poly=%0d last=%b cum=%0d want h=%0d idx=%0d poly=%0d cum=%0d",
                                 n_out, m_oh, m_ix, m_pp, m_pl, m_cc, exp_hint[n_out], n_out % NN,
                                 n_out / NN, exp_cum[n_out]);
                    end
                end
                n_out++;
            end
            stalled = m_ov && !out_ready;
            s_h = m_oh; s_ix = m_ix; s_pp = m_pp; s_cc = m_cc; s_pl = m_pl;
        end
        in_valid = 1'b0;
        if (abort_at < 0) begin
            total++;
            if (done_seen != 1 || n_out != beats) begin
                bad++;
                $display("FAIL pass_end got done_pulses=%0d beats=%0d want 1 %0d", done_seen, n_out, beats);
            end
            if (!bp) begin
                total++;
                if (done_cyc != beats + 2) begin
                    bad++;
                    $display("FAIL pass_latency got=%0d want=%0d (cycles incl. start)", done_cyc + 1, beats + 3);
                end
            end
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            total++;
            if ({m_ir, m_ov, m_oh, m_pl, m_bz, m_dn, m_of, m_ix, m_pp, m_cc, m_ct} !== '0) begin
                bad++;
                $display("FAIL reset_state inst=%0d got v=%b rdy=%b h=%b idx=%0d cum=%0d cnt=%0d want all 0",
                         s, m_ov, m_ir, m_oh, m_ix, m_cc, m_ct);
            end
        end
        sel = 0;
    endtask

    task automatic test_zero_stream();
        sel = 0;
        fill_zero();
        run_pass(6, 261888, 55, 1'b0, -1);
        total++;
        if (m_ct !== 32'd0 || m_of !== 1'b0) begin
            bad++;
            $display("FAIL zero_count got=%0d/%b want=0/0", m_ct, m_of);
        end
    endtask

    task automatic test_boundary();
        int want [5] = '{0, 1, 1, 0, 1};
        sel = 0;
        fill_zero();
        a0_mem[0] = 261888;  a1_mem[0] = 0;
        a0_mem[1] = 261889;  a1_mem[1] = 0;
        a0_mem[2] = -261889; a1_mem[2] = 0;
        a0_mem[3] = -261888; a1_mem[3] = 0;
        a0_mem[4] = -261888; a1_mem[4] = 5;
        run_pass(6, 261888, 55, 1'b0, -1);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (obs_hint[i] != want[i]) begin
                bad++;
                $display("FAIL boundary case=%0d got=%0d want=%0d", i, obs_hint[i], want[i]);
            end
        end
        total++;
        if (m_ct !== 32'd3) begin
            bad++;
            $display("FAIL boundary_count got=%0d want=3", m_ct);
        end
    endtask

    task automatic test_limit(int nh, logic want_of);
        int ptot [6];
        int acc;
        sel = 0;
        fill_zero();
        for (int p = 0; p < 6; p++) ptot[p] = 0;
        for (int j = 0; j < nh; j++) begin
            int pos;
            pos = j * 27 + int'($urandom_range(0, 26));
            a0_mem[pos] = (j % 2 == 0) ? 300000 : -300000;
            ptot[pos / NN]++;
        end
        run_pass(6, 261888, 55, 1'b0, -1);
        total++;
        if (m_ct !== 32'(nh) || m_of !== want_of || n_out != 1536) begin
            bad++;
            $display("FAIL limit_%0d got count=%0d ovf=%b beats=%0d want %0d %b 1536", nh, m_ct, m_of, n_out, nh, want_of);
        end
        acc = 0;
        for (int p = 0; p < 6; p++) begin
            acc += ptot[p];
            total++;
            if (obs_cum[p * NN + NN - 1] != acc || obs_last[p * NN + NN - 1] !== 1'b1) begin
                bad++;
                $display("FAIL poly_total p=%0d got cum=%0d last=%b want cum=%0d last=1",
                         p, obs_cum[p * NN + NN - 1], obs_last[p * NN + NN - 1], acc);
            end
        end
    endtask

    task automatic test_backpressure();
        sel = 0;
        fill_random(261888, 10);
        run_pass(6, 261888, 55, 1'b1, -1);
    endtask

    task automatic test_reset_mid_pass();
        sel = 0;
        fill_random(261888, 5);
        run_pass(6, 261888, 55, 1'b0, 700);
        rst_n = 1'b0;
        #1;
        total++;
        if ({m_ir, m_ov, m_oh, m_pl, m_bz, m_dn, m_of, m_ix, m_pp, m_cc, m_ct} !== '0) begin
            bad++;
            $display("FAIL mid_reset got v=%b rdy=%b h=%b idx=%0d poly=%0d cum=%0d busy=%b want all 0",
                     m_ov, m_ir, m_oh, m_ix, m_pp, m_cc, m_bz);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (m_dn !== 1'b0 || m_bz !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_idle got done=%b busy=%b want 0 0", m_dn, m_bz);
        end
        fill_random(261888, 3);
        run_pass(6, 261888, 55, 1'b0, -1);
    endtask

    task automatic test_params();
        sel = 1;
        fill_random(95232, 6);
        run_pass(4, 95232, 80, 1'b0, -1);
        total++;
        if (n_out != 1024) begin
            bad++;
            $display("FAIL k4_beats got=%0d want=1024", n_out);
        end
        sel = 2;
        fill_random(261888, 4);
        run_pass(8, 261888, 75, 1'b1, -1);
        total++;
        if (n_out != 2048) begin
            bad++;
            $display("FAIL k8_beats got=%0d want=2048", n_out);
        end
        sel = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        start_vec = 3'b000;
        in_valid = 1'b0;
        in_a0 = '0;
        in_a1 = '0;
        out_ready = 1'b0;
        sel = 0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_zero_stream();
        test_boundary();
        test_limit(55, 1'b0);
        test_limit(56, 1'b1);
        test_backpressure();
        test_reset_mid_pass();
        test_params();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
